// File: rtl/intr_ctrl.sv
// Vectored interrupt controller: synchronises and edge-detects irq lines, masks and
// prioritises them (index 0 highest) and hands one request plus vector to the CPU.
module intr_ctrl #(
  parameter int unsigned       N_IRQ      = 4,
  parameter int unsigned       VEC_W      = 10,
  parameter logic [VEC_W-1:0]  VEC_BASE   = 10'h3C0,
  parameter int unsigned       VEC_STRIDE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_in,
  input  logic             gie_set,
  input  logic             gie_clr,
  input  logic             int_ack,
  input  logic             int_ret,
  output logic             int_req,
  output logic [VEC_W-1:0] int_vec,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] in_serv,
  output logic [N_IRQ-1:0] mask,
  output logic             gie,
  output logic             ret_err
);

  localparam int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [N_IRQ-1:0]   irq_s1_q, irq_s2_q, irq_prev_q;
  logic [N_IRQ-1:0]   pending_q, pending_d;
  logic [N_IRQ-1:0]   in_serv_q, in_serv_d;
  logic [N_IRQ-1:0]   mask_q, mask_d;
  logic               gie_q, gie_d;
  logic               ret_err_q, ret_err_d;

  logic [N_IRQ-1:0]   edge_det;
  logic [N_IRQ-1:0]   eligible;
  logic [N_IRQ-1:0]   ack_sel;
  logic [N_IRQ-1:0]   ack_bits;
  logic [N_IRQ-1:0]   ret_lowest;
  logic [IDX_W-1:0]   win;
  logic               win_valid;
  logic               blocked;
  logic               ack_fire;

  function automatic logic [VEC_W-1:0] vec_of(input logic [IDX_W-1:0] idx);
    return VEC_W'(32'(VEC_BASE) + 32'(idx) * VEC_STRIDE);
  endfunction

  assign edge_det   = irq_s2_q & ~irq_prev_q;
  assign eligible   = pending_q & mask_q;
  assign ack_sel    = N_IRQ'(1) << idx_q;
  // Isolates the lowest set bit: the most recently nested (highest priority) service.
  assign ret_lowest = in_serv_q & (~in_serv_q + N_IRQ'(1));

  assign mask_d = mask_we ? mask_in : mask_q;
  assign gie_d  = gie_clr ? 1'b0 : (gie_set ? 1'b1 : gie_q);

  always_comb begin
    win_valid = 1'b0;
    win       = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_valid = 1'b1;
        win       = IDX_W'(i);
      end
    end
  end

  // A channel may nest only above everything already in service.
  always_comb begin
    blocked = 1'b0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (in_serv_q[i] && (i <= int'(win))) blocked = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    vec_d    = vec_q;
    ack_fire = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gie_q && win_valid && !blocked) begin
          state_d = StReq;
          idx_d   = win;
          vec_d   = vec_of(win);
        end
      end
      StReq: begin
        if (int_ack) begin
          ack_fire = 1'b1;
          state_d  = StHold;
        end else if (!gie_d || ((mask_d & ack_sel) == '0)) begin
          state_d = StIdle;
        end
      end
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign ack_bits  = ack_fire ? ack_sel : '0;
  assign pending_d = (pending_q & ~ack_bits) | edge_det;
  assign in_serv_d = (in_serv_q & ~(int_ret ? ret_lowest : '0)) | ack_bits;
  assign ret_err_d = ret_err_q | (int_ret & ~|in_serv_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      vec_q      <= '0;
      irq_s1_q   <= '0;
      irq_s2_q   <= '0;
      irq_prev_q <= '0;
      pending_q  <= '0;
      in_serv_q  <= '0;
      mask_q     <= '0;
      gie_q      <= 1'b0;
      ret_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      vec_q      <= vec_d;
      irq_s1_q   <= irq;
      irq_s2_q   <= irq_s1_q;
      irq_prev_q <= irq_s2_q;
      pending_q  <= pending_d;
      in_serv_q  <= in_serv_d;
      mask_q     <= mask_d;
      gie_q      <= gie_d;
      ret_err_q  <= ret_err_d;
    end
  end

  assign int_req = (state_q == StReq);
  assign int_vec = vec_q;
  assign pending = pending_q;
  assign in_serv = in_serv_q;
  assign mask    = mask_q;
  assign gie     = gie_q;
  assign ret_err = ret_err_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios with fixed expectations, then randomized
// traffic compared every cycle against a behavioural model of the controller.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       gie_set;
  logic       gie_clr;
  logic       int_ack;
  logic       int_ret;
  logic       int_req;
  logic [9:0] int_vec;
  logic [3:0] pending;
  logic [3:0] in_serv;
  logic [3:0] mask;
  logic       gie;
  logic       ret_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  intr_ctrl #(
    .N_IRQ     (4),
    .VEC_W     (10),
    .VEC_BASE  (10'h3C0),
    .VEC_STRIDE(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .irq    (irq),
    .mask_we(mask_we),
    .mask_in(mask_in),
    .gie_set(gie_set),
    .gie_clr(gie_clr),
    .int_ack(int_ack),
    .int_ret(int_ret),
    .int_req(int_req),
    .int_vec(int_vec),
    .pending(pending),
    .in_serv(in_serv),
    .mask   (mask),
    .gie    (gie),
    .ret_err(ret_err)
  );

  // Reference model: raw irq samples of the last three edges, plus the
  // controller's architectural state; phase 0 = no request, 1 = requesting, 2 = vectoring.
  typedef struct packed {
    logic [3:0] h0, h1, h2;
    logic [3:0] pend, insv, msk;
    logic       g, err;
    logic [1:0] phase;
    logic [1:0] chan;
  } mstate_t;

  mstate_t m = '0;

  function automatic mstate_t model_next(input mstate_t s, input logic rst, input logic [3:0] irq_v,
                                         input logic mwe, input logic [3:0] min, input logic gs,
                                         input logic gc, input logic ack, input logic ret);
    mstate_t    n;
    logic [3:0] rising;
    logic [3:0] nm;
    logic       ng;
    int         c;
    bit         ok;
    n = s;
    if (rst) begin
      n = '0;
      return n;
    end
    rising = s.h1 & ~s.h2;
    nm = mwe ? min : s.msk;
    ng = gc ? 1'b0 : (gs ? 1'b1 : s.g);
    if (ret) begin
      if (s.insv == 4'd0) n.err = 1'b1;
      else begin
        for (int i = 0; i < 4; i++) begin
          if (s.insv[i]) begin
            n.insv[i] = 1'b0;
            break;
          end
        end
      end
    end
    case (s.phase)
      2'd0: begin
        c = -1;
        for (int i = 0; i < 4; i++) begin
          if (s.pend[i] && s.msk[i]) begin
            c = i;
            break;
          end
        end
        if (c >= 0 && s.g) begin
          ok = 1'b1;
          for (int j = 0; j <= c; j++) if (s.insv[j]) ok = 1'b0;
          if (ok) begin
            n.phase = 2'd1;
            n.chan  = 2'(c);
          end
        end
      end
      2'd1: begin
        if (ack) begin
          n.pend[s.chan] = 1'b0;
          n.insv[s.chan] = 1'b1;
          n.phase        = 2'd2;
        end else if (!ng || !nm[s.chan]) begin
          n.phase = 2'd0;
        end
      end
      default: n.phase = 2'd0;
    endcase
    n.pend = n.pend | rising;
    n.msk  = nm;
    n.g    = ng;
    n.h2   = s.h1;
    n.h1   = s.h0;
    n.h0   = irq_v;
    return n;
  endfunction

  always @(posedge clk)
    m <= model_next(m, reset, irq, mask_we, mask_in, gie_set, gie_clr, int_ack, int_ret);

  function automatic logic [9:0] exp_vec(input int c);
    return 10'(32'h3C0 + 32'(4 * c));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    irq   = 4'd0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic setup(input logic [3:0] mval);
    mask_in = mval;
    mask_we = 1'b1;
    gie_set = 1'b1;
    tick();
    mask_we = 1'b0;
    gie_set = 1'b0;
  endtask

  task automatic wait_req(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (int_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (int_req === 1'b1) ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", int_req); end
    checks++; if (int_vec !== 10'd0) begin errors++; $display("FAIL rst_vec got %h want 000", int_vec); end
    checks++; if ({pending, in_serv, mask} !== 12'd0) begin
      errors++; $display("FAIL rst_regs got %b want 0", {pending, in_serv, mask});
    end
    checks++; if ({gie, ret_err} !== 2'b00) begin
      errors++; $display("FAIL rst_flags got %b want 00", {gie, ret_err});
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    setup(4'hF);
    irq = 4'b0100;
    tick();
    tick();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL single_early got %b want 0000", pending); end
    tick();
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL single_pend got %b want 0100", pending); end
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL single_req0 got %b want 0", int_req); end
    irq = 4'b0000;
    tick();
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL single_req got %b want 1", int_req); end
    checks++; if (int_vec !== 10'h3C8) begin errors++; $display("FAIL single_vec got %h want 3c8", int_vec); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL single_ackp got %b want 0000", pending); end
    checks++; if (in_serv !== 4'b0100) begin errors++; $display("FAIL single_isv got %b want 0100", in_serv); end
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL single_hold got %b want 0", int_req); end
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    checks++; if (in_serv !== 4'b0000) begin errors++; $display("FAIL single_ret got %b want 0000", in_serv); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    do_reset();
    setup(4'hF);
    irq = 4'b1010;
    tick(); tick(); tick();
    checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL simul_pend got %b want 1010", pending); end
    tick();
    checks++; if (int_vec !== 10'h3C4 || int_req !== 1'b1) begin
      errors++; $display("FAIL simul_first got req %b vec %h want 1 3c4", int_req, int_vec);
    end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checks++; if ({pending, in_serv} !== 8'b1000_0010) begin
      errors++; $display("FAIL simul_ack got %b want 10000010", {pending, in_serv});
    end
    tick(); tick(); tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL simul_blocked got %b want 0", int_req); end
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    wait_req(6, ok);
    checks++; if (!ok || int_vec !== 10'h3CC) begin
      errors++; $display("FAIL simul_second got req %b vec %h want 1 3cc", int_req, int_vec);
    end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    irq = 4'b0000;
  endtask

  task automatic test_nesting();
    bit ok;
    do_reset();
    setup(4'hF);
    irq = 4'b0100;
    wait_req(8, ok);
    checks++; if (!ok || int_vec !== 10'h3C8) begin
      errors++; $display("FAIL nest_outer got req %b vec %h want 1 3c8", int_req, int_vec);
    end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    irq = 4'b1101;
    wait_req(8, ok);
    checks++; if (!ok || int_vec !== 10'h3C0) begin
      errors++; $display("FAIL nest_inner got req %b vec %h want 1 3c0", int_req, int_vec);
    end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checks++; if ({pending, in_serv} !== 8'b1000_0101) begin
      errors++; $display("FAIL nest_both got %b want 10000101", {pending, in_serv});
    end
    tick(); tick(); tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL nest_wait1 got %b want 0", int_req); end
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    checks++; if (in_serv !== 4'b0100) begin errors++; $display("FAIL nest_ret1 got %b want 0100", in_serv); end
    tick(); tick(); tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL nest_wait2 got %b want 0", int_req); end
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    checks++; if (in_serv !== 4'b0000) begin errors++; $display("FAIL nest_ret2 got %b want 0000", in_serv); end
    wait_req(6, ok);
    checks++; if (!ok || int_vec !== 10'h3CC) begin
      errors++; $display("FAIL nest_last got req %b vec %h want 1 3cc", int_req, int_vec);
    end
    irq = 4'b0000;
  endtask

  task automatic test_mask();
    do_reset();
    setup(4'b1110);
    irq = 4'b0001;
    tick(); tick(); tick();
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL mask_pend got %b want 0001", pending); end
    tick(); tick(); tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL mask_noreq got %b want 0", int_req); end
    mask_in = 4'b1111;
    mask_we = 1'b1;
    tick();
    mask_we = 1'b0;
    checks++; if (int_req !== 1'b0 || mask !== 4'b1111) begin
      errors++; $display("FAIL mask_load got req %b mask %b want 0 1111", int_req, mask);
    end
    tick();
    checks++; if (int_req !== 1'b1 || int_vec !== 10'h3C0) begin
      errors++; $display("FAIL mask_req got req %b vec %h want 1 3c0", int_req, int_vec);
    end
    irq = 4'b0000;
  endtask

  task automatic test_gie_withdraw();
    bit ok;
    do_reset();
    setup(4'hF);
    irq = 4'b0010;
    wait_req(8, ok);
    checks++; if (!ok || int_vec !== 10'h3C4) begin
      errors++; $display("FAIL gie_first got req %b vec %h want 1 3c4", int_req, int_vec);
    end
    gie_clr = 1'b1;
    tick();
    gie_clr = 1'b0;
    checks++; if ({int_req, gie, pending} !== 6'b00_0010) begin
      errors++; $display("FAIL gie_withdraw got %b want 000010", {int_req, gie, pending});
    end
    tick(); tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL gie_off got %b want 0", int_req); end
    gie_set = 1'b1;
    tick();
    gie_set = 1'b0;
    wait_req(4, ok);
    checks++; if (!ok || int_vec !== 10'h3C4) begin
      errors++; $display("FAIL gie_reissue got req %b vec %h want 1 3c4", int_req, int_vec);
    end
    int_ack = 1'b1;
    gie_clr = 1'b1;
    tick();
    int_ack = 1'b0;
    gie_clr = 1'b0;
    checks++; if ({gie, pending, in_serv} !== 9'b0_0000_0010) begin
      errors++; $display("FAIL gie_ackwins got %b want 000000010", {gie, pending, in_serv});
    end
    irq = 4'b0000;
  endtask

  task automatic test_ret_err_reset();
    bit ok;
    do_reset();
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    checks++; if (ret_err !== 1'b1) begin errors++; $display("FAIL reterr_set got %b want 1", ret_err); end
    tick(); tick();
    checks++; if (ret_err !== 1'b1) begin errors++; $display("FAIL reterr_sticky got %b want 1", ret_err); end
    setup(4'hF);
    irq = 4'b1000;
    wait_req(8, ok);
    checks++; if (!ok || int_vec !== 10'h3CC) begin
      errors++; $display("FAIL reterr_req got req %b vec %h want 1 3cc", int_req, int_vec);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    irq = 4'b0000;
    checks++; if ({int_req, pending, ret_err, gie, mask} !== 11'd0) begin
      errors++; $display("FAIL reterr_reset got %b want 0", {int_req, pending, ret_err, gie, mask});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) irq[b] = ~irq[b];
      mask_we = ($urandom_range(15) == 0);
      mask_in = 4'($urandom_range(15));
      gie_set = ($urandom_range(9) == 0);
      gie_clr = ($urandom_range(24) == 0);
      int_ack = ($urandom_range(1) == 0);
      int_ret = ($urandom_range(7) == 0);
      reset   = ($urandom_range(399) == 0);
      tick();
      checks++; if (int_req !== (m.phase == 2'd1)) begin
        errors++; $display("FAIL rand_req cyc %0d got %b want %b", cyc, int_req, m.phase == 2'd1);
      end
      if (m.phase == 2'd1) begin
        checks++; if (int_vec !== exp_vec(int'(m.chan))) begin
          errors++; $display("FAIL rand_vec cyc %0d got %h want %h", cyc, int_vec, exp_vec(int'(m.chan)));
        end
      end
      checks++; if (pending !== m.pend) begin
        errors++; $display("FAIL rand_pend cyc %0d got %b want %b", cyc, pending, m.pend);
      end
      checks++; if (in_serv !== m.insv) begin
        errors++; $display("FAIL rand_isv cyc %0d got %b want %b", cyc, in_serv, m.insv);
      end
      checks++; if ({mask, gie, ret_err} !== {m.msk, m.g, m.err}) begin
        errors++; $display("FAIL rand_ctl cyc %0d got %b want %b", cyc, {mask, gie, ret_err},
                           {m.msk, m.g, m.err});
      end
    end
    {mask_we, gie_set, gie_clr, int_ack, int_ret, reset} = 6'd0;
  endtask

  initial begin
    reset   = 1'b1;
    irq     = 4'd0;
    mask_we = 1'b0;
    mask_in = 4'd0;
    gie_set = 1'b0;
    gie_clr = 1'b0;
    int_ack = 1'b0;
    int_ret = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_nesting();
    test_mask();
    test_gie_withdraw();
    test_ret_err_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
